textbuf_ctrl: RTL and testbench
===============================

// Module: textbuf_ctrl
// PURPOSE
//  Parametrised text-mode character store that replaces the fixed 4096x8 buffer.
//  Host side writes and reads cells by (col,row); the video side reads cells every pixel clock.
//  Built-in command engine: clear-screen, clear-row, and hardware scroll-up through a rotating top-row pointer.
//  Sits between the terminal/ANSI parser (host) and the glyph renderer (video).
// PARAMETERS
//  COLS    80     cells per row
//  ROWS    30     rows per screen
//  COL_W   7      column index width, 2**COL_W >= COLS
//  ROW_W   5      row index width, 2**ROW_W >= ROWS
//  DATA_W  8      cell width (char code, optionally + attribute bits)
//  FILL    8'h20  value written by clear operations, zero-extended to DATA_W
// PORTS
//  clk         in   1       single clock for host, command and video sides
//  reset       in   1       synchronous, active-high
//  host_valid  in   1       host request
//  host_ready  out  1       request accepted when host_valid && host_ready
//  host_we     in   1       1=write, 0=read
//  host_col    in   COL_W   logical column
//  host_row    in   ROW_W   logical row
//  host_wdata  in   DATA_W  write data
//  host_rvalid out  1       read data valid, one-cycle pulse
//  host_rdata  out  DATA_W  read data, held until the next rvalid
//  cmd_valid   in   1       command request
//  cmd_ready   out  1       command accepted when cmd_valid && cmd_ready
//  cmd_op      in   2       00 nop, 01 clear screen, 10 scroll up, 11 clear row
//  cmd_row     in   ROW_W   logical row for op 11
//  vid_en      in   1       video read enable
//  vid_col     in   COL_W   video logical column
//  vid_row     in   ROW_W   video logical row
//  vid_data    out  DATA_W  video cell, 2-cycle latency; holds its value when vid_en=0
//  top_row     out  ROW_W   current physical row shown as logical row 0
// BEHAVIOUR
//  - Mapping: phys_row = logical_row + top_row, minus ROWS if the sum >= ROWS (compare/subtract, no divider).
//    Address = phys_row*COLS + col. Storage is COLS*ROWS words in dual-port BRAM. The video port is read-only.
//  - Reset: state=IDLE, top_row=0, host_rvalid=0, host_rdata=0, vid_data=0. Memory is not cleared by reset.
//  - FSM states: IDLE, CLR_SCR, CLR_ROW.
//    In IDLE: cmd_ready=1 and host_ready=!cmd_valid, so a command wins over a simultaneous host request.
//    In CLR_*: cmd_ready=0 and host_ready=0.
//  - Command handling:
//    - Op 01: enter CLR_SCR and write FILL to physical addresses 0..COLS*ROWS-1, one per cycle, then return to IDLE.
//      Busy for COLS*ROWS cycles. top_row is unchanged.
//    - Op 10: on accept, top_row <= (top_row==ROWS-1) ? 0 : top_row+1.
//      Then enter CLR_ROW on the old top_row physical row (the new bottom logical row). Busy for COLS cycles.
//    - Op 11: enter CLR_ROW on the physical row mapped from cmd_row. Busy for COLS cycles.
//      If cmd_row >= ROWS: accepted as a nop, no busy cycles.
//    - Op 00: accepted, no effect.
//  - Host port:
//    - Write: committed on the accept cycle.
//    - Read: host_rvalid pulses exactly 2 cycles after accept.
//    - Back-to-back accepts are allowed, one per cycle, and reads stay in order.
//    - A read issued on the cycle after a write to the same cell returns the new data (write-first).
//  - Range: col >= COLS or row >= ROWS. Such host writes are dropped; such host reads return FILL.
//    Out-of-range video reads return FILL.
//  - Video: independent of the FSM, never stalled. Reads during a clear may return old or FILL data.
//    A new top_row is used by video addresses from the cycle after the scroll accept.
//  - Reset mid-clear: aborts immediately to IDLE. Partially cleared memory is left as is.
//    In-flight host_rvalid is cancelled.
// CONFIGURATION
//  TEXTBUF_READBACK_EN defined:
//    - Host reads work as described in BEHAVIOUR.
//  TEXTBUF_READBACK_EN undefined:
//    - Host port A is write-only, so simple-dual-port BRAM is inferred.
//    - Reads are accepted and ignored: host_rvalid stays 0 and host_rdata stays 0.
// TESTING
//  1. Reset, op 01, wait for cmd_ready; video-read (0,0) and (79,29) -> vid_data=8'h20 two cycles after each read.
//  2. Host write 8'h41 at (3,2), then read (3,2) -> host_rvalid at +2 cycles, host_rdata=8'h41;
//     a video read of (3,2) returns 8'h41.
//  3. Write 8'h42 at row 1, col 0; op 10 -> top_row=1, cmd_ready low 80 cycles;
//     video (0,0)=8'h42, and logical row 29 reads all 8'h20.
//  4. Issue 30 op-10 commands -> top_row wraps 29->0; logical-to-physical mapping verified against a reference model.
//  5. cmd_valid and host_valid in the same IDLE cycle -> command accepted, host_ready=0;
//     the host request is accepted after the clear completes.
//  6. Host write at (80,0) or (0,30) -> no memory change; host read of the same cell -> 8'h20.
//     With the macro off, any read -> host_rvalid never asserts.

Source files
------------

// File: rtl/textbuf_ctrl.sv
// Text-mode character store with a clear/scroll command engine and a free-running video read port.
// Optional macro TEXTBUF_READBACK_EN enables host reads; without it the host port is write-only.

module textbuf_ctrl #(
  parameter int         COLS   = 80,
  parameter int         ROWS   = 30,
  parameter int         COL_W  = 7,
  parameter int         ROW_W  = 5,
  parameter int         DATA_W = 8,
  parameter logic [7:0] FILL   = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [COL_W-1:0]  host_col,
  input  logic [ROW_W-1:0]  host_row,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic              vid_en,
  input  logic [COL_W-1:0]  vid_col,
  input  logic [ROW_W-1:0]  vid_row,
  output logic [DATA_W-1:0] vid_data,
  output logic [ROW_W-1:0]  top_row
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CLR_SCR = 2'd1;
  localparam logic [1:0] CLR_ROW = 2'd2;

  function automatic logic in_range(input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row);
    return ({1'b0, col} < (COL_W+1)'(COLS)) && ({1'b0, row} < (ROW_W+1)'(ROWS));
  endfunction

  // Rotating top-row pointer: wrap with a compare/subtract instead of a modulo.
  function automatic logic [ROW_W-1:0] map_row(input logic [ROW_W-1:0] lrow,
                                               input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= (ROW_W+1)'(ROWS))
      sum = sum - (ROW_W+1)'(ROWS);
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  logic [1:0]        state_reg, state_next;
  logic [ROW_W-1:0]  top_row_reg, top_row_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic [ADDR_W-1:0] clr_base_reg, clr_base_next;

  logic              host_ok, vid_ok, cmd_row_ok;
  logic [ADDR_W-1:0] host_addr, vid_addr;
  logic              host_fire, cmd_fire;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              vid_vld_reg, vid_oor_reg;
  logic [DATA_W-1:0] vid_rd_reg, vid_data_reg;

  assign cmd_ready  = (state_reg == IDLE);
  assign host_ready = (state_reg == IDLE) && !cmd_valid;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign host_fire  = host_valid && host_ready;

  assign host_ok    = in_range(host_col, host_row);
  assign vid_ok     = in_range(vid_col, vid_row);
  assign cmd_row_ok = ({1'b0, cmd_row} < (ROW_W+1)'(ROWS));
  assign host_addr  = host_ok ? cell_addr(map_row(host_row, top_row_reg), host_col) : '0;
  assign vid_addr   = vid_ok ? cell_addr(map_row(vid_row, top_row_reg), vid_col) : '0;

  assign top_row  = top_row_reg;
  assign vid_data = vid_data_reg;

  always_comb begin
    state_next    = state_reg;
    top_row_next  = top_row_reg;
    clr_cnt_next  = clr_cnt_reg;
    clr_base_next = clr_base_reg;
    mem_we        = 1'b0;
    mem_waddr     = host_addr;
    mem_wdata     = host_wdata;
    case (state_reg)
      IDLE: begin
        mem_we = host_fire && host_we && host_ok;
        if (cmd_fire) begin
          clr_cnt_next = '0;
          case (cmd_op)
            2'b01: begin
              clr_base_next = '0;
              state_next    = CLR_SCR;
            end
            2'b10: begin
              // The old top row becomes the new bottom row and is blanked.
              top_row_next  = (top_row_reg == ROW_W'(ROWS-1)) ? '0 : top_row_reg + ROW_W'(1);
              clr_base_next = cell_addr(top_row_reg, '0);
              state_next    = CLR_ROW;
            end
            2'b11: begin
              if (cmd_row_ok) begin
                clr_base_next = cell_addr(map_row(cmd_row, top_row_reg), '0);
                state_next    = CLR_ROW;
              end
            end
            default: ;
          endcase
        end
      end
      CLR_SCR, CLR_ROW: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_base_reg + clr_cnt_reg;
        mem_wdata    = FILL_WORD;
        clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
        if (clr_cnt_reg == ((state_reg == CLR_SCR) ? ADDR_W'(DEPTH-1) : ADDR_W'(COLS-1)))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset aborts a clear on the very cycle it is asserted.
    if (reset)
      mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      top_row_reg  <= '0;
      clr_cnt_reg  <= '0;
      clr_base_reg <= '0;
      vid_vld_reg  <= 1'b0;
      vid_oor_reg  <= 1'b0;
      vid_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      top_row_reg  <= top_row_next;
      clr_cnt_reg  <= clr_cnt_next;
      clr_base_reg <= clr_base_next;
      vid_vld_reg  <= vid_en;
      vid_oor_reg  <= !vid_ok;
      if (vid_vld_reg)
        vid_data_reg <= vid_oor_reg ? FILL_WORD : vid_rd_reg;
    end
  end

`ifdef TEXTBUF_READBACK_EN
  logic              host_rd_vld_reg, host_rd_oor_reg, host_rvalid_reg;
  logic [DATA_W-1:0] host_rd_reg, host_rdata_reg;

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    vid_rd_reg  <= mem[vid_addr];
    host_rd_reg <= mem[host_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      host_rd_vld_reg <= 1'b0;
      host_rd_oor_reg <= 1'b0;
      host_rvalid_reg <= 1'b0;
      host_rdata_reg  <= '0;
    end else begin
      host_rd_vld_reg <= host_fire && !host_we;
      host_rd_oor_reg <= !host_ok;
      host_rvalid_reg <= host_rd_vld_reg;
      if (host_rd_vld_reg)
        host_rdata_reg <= host_rd_oor_reg ? FILL_WORD : host_rd_reg;
    end
  end

  assign host_rvalid = host_rvalid_reg;
  assign host_rdata  = host_rdata_reg;
`else
  // Host side only writes, so the store maps onto a simple dual-port RAM.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    vid_rd_reg <= mem[vid_addr];
  end

  assign host_rvalid = 1'b0;
  assign host_rdata  = '0;
`endif

endmodule

// File: tb/tb_textbuf_ctrl.sv
// Randomized scoreboard bench for textbuf_ctrl; the reference keeps the logical screen as a 2-D array
// and scrolls by shifting rows, independent of the DUT's rotating pointer.

module tb_textbuf_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;
  localparam int DEPTH = COLS * ROWS;
  localparam logic [7:0] FILLV = 8'h20;
  localparam int BOUND = 5000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             host_valid = 1'b0;
  logic             host_ready;
  logic             host_we = 1'b0;
  logic [COL_W-1:0] host_col = '0;
  logic [ROW_W-1:0] host_row = '0;
  logic [7:0]       host_wdata = '0;
  logic             host_rvalid;
  logic [7:0]       host_rdata;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [ROW_W-1:0] cmd_row = '0;
  logic             vid_en = 1'b0;
  logic [COL_W-1:0] vid_col = '0;
  logic [ROW_W-1:0] vid_row = '0;
  logic [7:0]       vid_data;
  logic [ROW_W-1:0] top_row;

  textbuf_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .DATA_W(8), .FILL(FILLV)
  ) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_col(host_col), .host_row(host_row), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_row(cmd_row),
    .vid_en(vid_en), .vid_col(vid_col), .vid_row(vid_row), .vid_data(vid_data),
    .top_row(top_row)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [7:0] d; } exp_t;
  exp_t host_q[$];
  exp_t vid_q[$];
  exp_t mon_h, mon_v;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rv_seen = 0;
  bit mon_en = 1'b0;
  logic [7:0] last_vid = '0;

  logic [7:0] scr [ROWS][COLS];
  int top_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_cell(input int c, input int r);
    if (c >= COLS || r >= ROWS) return FILLV;
    return scr[r][c];
  endfunction

  // Scoreboard monitor: pops expectations when the DUT presents read data.
  always @(negedge clk) begin
    if (host_rvalid) begin
      rv_seen++;
      if (host_q.size() == 0) begin
        check("host_rvalid_unexpected", int'(host_rvalid), 0);
      end else begin
        mon_h = host_q.pop_front();
        check("host_rd_cycle", cyc, mon_h.due);
        check("host_rdata", int'(host_rdata), int'(mon_h.d));
      end
    end else if (host_q.size() != 0 && host_q[0].due <= cyc) begin
      mon_h = host_q.pop_front();
      check("host_rvalid_missing", int'(host_rvalid), 1);
    end
    if (vid_q.size() != 0 && vid_q[0].due == cyc) begin
      mon_v = vid_q.pop_front();
      check("vid_data", int'(vid_data), int'(mon_v.d));
      last_vid = mon_v.d;
    end else if (mon_en && !reset) begin
      check("vid_hold", int'(vid_data), int'(last_vid));
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    host_q.delete();
    vid_q.delete();
    last_vid = '0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    top_m = 0;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_top_row", int'(top_row), 0);
    check("rst_host_rvalid", int'(host_rvalid), 0);
    check("rst_host_rdata", int'(host_rdata), 0);
    check("rst_vid_data", int'(vid_data), 0);
  endtask

  task automatic wait_host_ready();
    int n = 0;
    while (!host_ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    if (!host_ready) check("host_ready_timeout", int'(host_ready), 1);
  endtask

  task automatic host_write(input int c, input int r, input logic [7:0] d);
    host_valid = 1'b1; host_we = 1'b1;
    host_col = COL_W'(c); host_row = ROW_W'(r); host_wdata = d;
    wait_host_ready();
    @(posedge clk); #1;
    host_valid = 1'b0; host_we = 1'b0;
    if (c < COLS && r < ROWS) scr[r][c] = d;
  endtask

  task automatic host_read(input int c, input int r);
    int acc;
    host_valid = 1'b1; host_we = 1'b0;
    host_col = COL_W'(c); host_row = ROW_W'(r);
    wait_host_ready();
    @(posedge clk); #1;
    acc = cyc;
    host_valid = 1'b0;
`ifdef TEXTBUF_READBACK_EN
    host_q.push_back('{acc + 1, exp_cell(c, r)});
`else
    if (acc < 0) host_q.push_back('{acc + 1, exp_cell(c, r)});
`endif
  endtask

  task automatic vid_read(input int c, input int r);
    int acc;
    vid_en = 1'b1; vid_col = COL_W'(c); vid_row = ROW_W'(r);
    @(posedge clk); #1;
    acc = cyc;
    vid_en = 1'b0;
    vid_q.push_back('{acc + 1, exp_cell(c, r)});
  endtask

  task automatic model_cmd(input logic [1:0] op, input int r, output int busy);
    busy = 0;
    case (op)
      2'b01: begin
        for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) scr[i][j] = FILLV;
        busy = DEPTH;
      end
      2'b10: begin
        for (int i = 0; i < ROWS - 1; i++) for (int j = 0; j < COLS; j++) scr[i][j] = scr[i+1][j];
        for (int j = 0; j < COLS; j++) scr[ROWS-1][j] = FILLV;
        top_m = (top_m + 1) % ROWS;
        busy = COLS;
      end
      2'b11: begin
        if (r < ROWS) begin
          for (int j = 0; j < COLS; j++) scr[r][j] = FILLV;
          busy = COLS;
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_cmd(input logic [1:0] op, input int r);
    int n;
    int exp_busy;
    cmd_valid = 1'b1; cmd_op = op; cmd_row = ROW_W'(r);
    n = 0;
    while (!cmd_ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_cmd(op, r, exp_busy);
    n = 0;
    while (!cmd_ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_busy_cycles", n, exp_busy);
    check("top_row", int'(top_row), top_m);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, c, r, n, busy;
    @(posedge clk); #1;
    do_reset(3);
    mon_en = 1'b1;

    // Clear screen, then corner cells
    do_cmd(2'b01, 0);
    vid_read(0, 0);
    vid_read(COLS-1, ROWS-1);

    // Write then back-to-back readback, plus video view
    host_write(3, 2, 8'h41);
    host_read(3, 2);
    vid_read(3, 2);

    // Scroll moves row 1 to row 0 and blanks the bottom row
    host_write(0, 1, 8'h42);
    do_cmd(2'b10, 0);
    check("scroll_top_row_1", int'(top_row), 1);
    vid_read(0, 0);
    for (int j = 0; j < COLS; j++) vid_read(j, ROWS-1);

    // Thirty scrolls wrap the pointer; mark the bottom row each time
    for (int i = 0; i < ROWS; i++) begin
      do_cmd(2'b10, 0);
      host_write(7, ROWS-1, 8'(8'h80 + i));
      vid_read(7, $urandom_range(0, ROWS-1));
      vid_read(7, ROWS-1);
    end

    // Command wins over a simultaneous host request
    host_valid = 1'b1; host_we = 1'b1; host_col = 7'd9; host_row = 5'd4; host_wdata = 8'h5a;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_row = 5'd4;
    #1;
    check("collide_host_ready", int'(host_ready), 0);
    check("collide_cmd_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_cmd(2'b11, 4, busy);
    n = 0;
    while (!host_ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    check("collide_host_wait", n, COLS);
    @(posedge clk); #1;
    host_valid = 1'b0; host_we = 1'b0;
    scr[4][9] = 8'h5a;
    vid_read(9, 4);
    vid_read(10, 4);

    // Out-of-range accesses
    host_write(COLS, 0, 8'h55);
    host_write(0, ROWS, 8'h66);
    host_read(COLS, 0);
    host_read(0, ROWS);
    vid_read(COLS, 0);
    vid_read(0, ROWS);
    vid_read(0, 1);
    vid_read(0, 0);
    do_cmd(2'b11, ROWS + 1);
    do_cmd(2'b00, 0);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 99);
      c = ($urandom_range(0, 9) == 0) ? $urandom_range(COLS, 127) : $urandom_range(0, COLS-1);
      r = ($urandom_range(0, 9) == 0) ? $urandom_range(ROWS, 31) : $urandom_range(0, ROWS-1);
      if (k < 35)      host_write(c, r, 8'($urandom_range(0, 255)));
      else if (k < 55) host_read(c, r);
      else if (k < 88) vid_read(c, r);
      else if (k < 93) do_cmd(2'b10, 0);
      else if (k < 97) do_cmd(2'b11, r);
      else if (k < 99) do_cmd(2'b00, 0);
      else             do_cmd(2'b01, 0);
    end

    // Reset in the middle of a clear, and with a read in flight
    cmd_valid = 1'b1; cmd_op = 2'b01;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_clear_busy", int'(cmd_ready), 0);
    do_reset(1);
    host_read(1, 1);
    do_reset(1);
    do_cmd(2'b01, 0);
    host_write(5, 5, 8'h77);
    host_read(5, 5);
    vid_read(5, 5);
    vid_read(6, 5);

    repeat (5) @(posedge clk);
    #1;
    check("drain_host_q", host_q.size(), 0);
    check("drain_vid_q", vid_q.size(), 0);
`ifndef TEXTBUF_READBACK_EN
    check("rvalid_never", rv_seen, 0);
    check("rdata_zero", int'(host_rdata), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
